// File: rtl/layer_update_scheduler_if.sv
// Signal bundle between the layer update scheduler and the layers/updater it steers.
// Latency: none, wires only.
// Backpressure: none; requests are pulses and completion is reported by done strobes.
interface layer_update_scheduler_if #(
    parameter int LAYER_NUM        = 4,
    parameter int LAYER_ADDR_WIDTH = 2
);
    logic [LAYER_NUM-1:0]        req;
    logic                        upd_valid;
    logic                        upd_error;
    logic [LAYER_ADDR_WIDTH-1:0] layer_sel;
    logic                        upd_start;
    logic                        wr_en;
    logic [LAYER_NUM-1:0]        done;
    logic                        busy;
    logic                        err;
    logic [LAYER_ADDR_WIDTH-1:0] err_layer;
    logic                        timeout;

    modport master (
        input  req, upd_valid, upd_error,
        output layer_sel, upd_start, wr_en, done, busy, err, err_layer, timeout
    );

    modport slave (
        output req, upd_valid, upd_error,
        input  layer_sel, upd_start, wr_en, done, busy, err, err_layer, timeout
    );
endinterface

// File: rtl/layer_update_scheduler.sv
// Round-robin sequencer time-sharing one weight_updater between layers; `UPDATE_TIMEOUT_EN adds a WAIT watchdog.
// Latency: req -> layer_sel 2 cycles, -> upd_start 3 cycles; upd_valid -> wr_en/done 1 cycle; 5 cycles overhead per job.
// Backpressure: none; requests merge into one pending bit per layer and wait for their round-robin turn.
module layer_update_scheduler #(
    parameter int LAYER_NUM        = 4,
    parameter int LAYER_ADDR_WIDTH = 2,
    parameter int TIMEOUT_CYCLES   = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    layer_update_scheduler_if.master bus
);
    typedef enum logic [1:0] {IDLE, LOAD, WAIT, WRITE} state_t;

    state_t                      state, state_nxt;
    logic [LAYER_NUM-1:0]        pending, pending_nxt;
    logic [LAYER_ADDR_WIDTH-1:0] last, last_nxt;
    logic [LAYER_ADDR_WIDTH-1:0] layer_sel, layer_sel_nxt;
    logic                        upd_start, upd_start_nxt;
    logic                        wr_en, wr_en_nxt;
    logic [LAYER_NUM-1:0]        done, done_nxt;
    logic                        err, err_nxt;
    logic [LAYER_ADDR_WIDTH-1:0] err_layer, err_layer_nxt;
    logic                        job_err, job_err_nxt;
    logic                        timeout_flag, timeout_nxt;
    logic [LAYER_ADDR_WIDTH-1:0] grant;
    logic [LAYER_NUM-1:0]        grant_mask;
    logic [LAYER_NUM-1:0]        sel_onehot;
    logic                        job_fail;
    logic                        wd_expired;

    function automatic logic [LAYER_ADDR_WIDTH-1:0] rr_index(input logic [LAYER_ADDR_WIDTH-1:0] base,
                                                             input int k);
        int sum;
        sum = int'(base) + k;
        if (sum >= LAYER_NUM) sum = sum - LAYER_NUM;
        return LAYER_ADDR_WIDTH'(sum);
    endfunction

    // Scan from farthest to nearest so the nearest pending index after last wins.
    always_comb begin
        grant = last;
        for (int k = LAYER_NUM; k >= 1; k--) begin
            if (pending[rr_index(last, k)]) grant = rr_index(last, k);
        end
    end

    assign grant_mask = {{(LAYER_NUM-1){1'b0}}, 1'b1} << grant;
    assign sel_onehot = {{(LAYER_NUM-1){1'b0}}, 1'b1} << layer_sel;
    assign job_fail   = job_err || bus.upd_error;

`ifdef UPDATE_TIMEOUT_EN
    logic [7:0] wd;

    always_ff @(posedge clk) begin
        if (rst)                 wd <= '0;
        else if (state == LOAD)  wd <= '0;
        else if (state == WAIT)  wd <= wd + 8'd1;
    end

    assign wd_expired = (state == WAIT) && (wd == 8'(TIMEOUT_CYCLES)) && !bus.upd_valid;
`else
    logic [31:0] unused_timeout_cfg;
    assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pending      <= '0;
            last         <= LAYER_ADDR_WIDTH'(LAYER_NUM - 1);
            layer_sel    <= '0;
            upd_start    <= 1'b0;
            wr_en        <= 1'b0;
            done         <= '0;
            err          <= 1'b0;
            err_layer    <= '0;
            job_err      <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            state        <= state_nxt;
            pending      <= pending_nxt;
            last         <= last_nxt;
            layer_sel    <= layer_sel_nxt;
            upd_start    <= upd_start_nxt;
            wr_en        <= wr_en_nxt;
            done         <= done_nxt;
            err          <= err_nxt;
            err_layer    <= err_layer_nxt;
            job_err      <= job_err_nxt;
            timeout_flag <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|pending) state_nxt = LOAD;
            LOAD:    state_nxt = WAIT;
            WAIT:    if (bus.upd_valid || wd_expired) state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A request landing on the grant cycle re-sets the bit being cleared.
    always_comb begin
        pending_nxt   = pending | bus.req;
        last_nxt      = last;
        layer_sel_nxt = layer_sel;
        upd_start_nxt = 1'b0;
        wr_en_nxt     = 1'b0;
        done_nxt      = '0;
        err_nxt       = err;
        err_layer_nxt = err_layer;
        job_err_nxt   = job_err;
        timeout_nxt   = timeout_flag;
        case (state)
            IDLE: begin
                if (|pending) begin
                    layer_sel_nxt = grant;
                    last_nxt      = grant;
                    pending_nxt   = (pending & ~grant_mask) | bus.req;
                end
            end
            LOAD: begin
                upd_start_nxt = 1'b1;
                job_err_nxt   = 1'b0;
            end
            WAIT: begin
                if (bus.upd_error) job_err_nxt = 1'b1;
                if (bus.upd_valid) begin
                    done_nxt = sel_onehot;
                    if (job_fail) begin
                        err_nxt       = 1'b1;
                        err_layer_nxt = layer_sel;
                    end else begin
                        wr_en_nxt = 1'b1;
                    end
                end else if (wd_expired) begin
                    done_nxt      = sel_onehot;
                    timeout_nxt   = 1'b1;
                    err_nxt       = 1'b1;
                    err_layer_nxt = layer_sel;
                end
            end
            default: ;
        endcase
    end

    assign bus.layer_sel = layer_sel;
    assign bus.upd_start = upd_start;
    assign bus.wr_en     = wr_en;
    assign bus.done      = done;
    assign bus.busy      = (state != IDLE);
    assign bus.err       = err;
    assign bus.err_layer = err_layer;
    assign bus.timeout   = timeout_flag;
endmodule

// File: tb/tb_layer_update_scheduler.sv
// Self-checking bench for layer_update_scheduler: transaction-level round-robin model feeds a scoreboard,
// a behavioural updater answers upd_start, and a monitor checks every done pulse.
module tb_layer_update_scheduler;
    localparam int NL = 4;
    localparam int AW = 2;
    localparam int TO = 20;

    typedef struct {
        int layer;
        bit wr;
        bit err;
        int err_layer;
    } exp_t;

    logic clk;
    logic rst;

    layer_update_scheduler_if #(.LAYER_NUM(NL), .LAYER_ADDR_WIDTH(AW)) sif ();

    layer_update_scheduler #(
        .LAYER_NUM(NL), .LAYER_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(sif)
    );

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            n_checks = 0;
    int            n_pass   = 0;
    int            m_last;
    bit            m_err;
    int            m_err_layer;
    int            lat_fixed = 0;
    bit            upd_hang  = 0;
    logic [NL-1:0] err_mask  = '0;
    int            starts    = 0;
    int            u_lat, u_errc;
    bit            u_inj;
    int            wr_cyc, busy10, busy11, cnt;
    bit            found;
    logic [NL-1:0] rv, ev;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish within the time limit");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_req(input logic [NL-1:0] v);
        sif.req = v;
        step(1);
        sif.req = '0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_last      = NL - 1;
        m_err       = 1'b0;
        m_err_layer = 0;
    endtask

    // Requests from an idle scheduler are served nearest-after-last first; failed jobs update the sticky error.
    task automatic model_batch(input logic [NL-1:0] r, input logic [NL-1:0] emask);
        logic [NL-1:0] p;
        int   g;
        int   idx;
        exp_t e;
        p = r;
        while (p != '0) begin
            g = -1;
            for (int k = 1; k <= NL; k++) begin
                idx = (m_last + k) % NL;
                if (g < 0 && p[idx]) g = idx;
            end
            p[g]   = 1'b0;
            m_last = g;
            if (emask[g]) begin
                m_err       = 1'b1;
                m_err_layer = g;
            end
            e.layer     = g;
            e.wr        = !emask[g];
            e.err       = m_err;
            e.err_layer = m_err_layer;
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || sif.busy) && n < 2000) begin
            step(1);
            n++;
        end
        check("drain_within_budget", int'(n < 2000), 1);
        step(2);
    endtask

    task automatic wait_start(input string name, input int want_layer, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 300) begin
            if (sif.upd_start && (want_layer < 0 || int'(sif.layer_sel) == want_layer)) ok = 1'b1;
            else begin
                step(1);
                n++;
            end
        end
        check(name, int'(ok), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_layer_sel"}, int'(sif.layer_sel), 0);
        check({tag, "_upd_start"}, int'(sif.upd_start), 0);
        check({tag, "_wr_en"},     int'(sif.wr_en),     0);
        check({tag, "_done"},      int'(sif.done),      0);
        check({tag, "_busy"},      int'(sif.busy),      0);
        check({tag, "_err"},       int'(sif.err),       0);
        check({tag, "_err_layer"}, int'(sif.err_layer), 0);
        check({tag, "_timeout"},   int'(sif.timeout),   0);
    endtask

    // Behavioural updater: valid lat cycles after start, optional one-cycle error, aborts on reset.
    initial begin
        sif.upd_valid = 1'b0;
        sif.upd_error = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && sif.upd_start && !upd_hang) begin
                u_lat  = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(2, 8));
                u_inj  = err_mask[sif.layer_sel];
                u_errc = int'($urandom_range(1, u_lat));
                for (int i = 1; i <= u_lat; i++) begin
                    @(negedge clk);
                    if (rst) break;
                    sif.upd_error = u_inj && (i == u_errc);
                    sif.upd_valid = (i == u_lat);
                end
                if (!rst) @(negedge clk);
                sif.upd_valid = 1'b0;
                sif.upd_error = 1'b0;
            end
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst) begin
            starts = 0;
        end else begin
            if (sif.upd_start) starts++;
            if (sif.wr_en) check("wr_en_has_done", int'(sif.done != '0), 1);
            if (sif.done != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", int'(sif.done), 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("done_onehot",   int'(sif.done),      1 << mon_e.layer);
                    check("done_layer_sel", int'(sif.layer_sel), mon_e.layer);
                    check("done_wr_en",    int'(sif.wr_en),     int'(mon_e.wr));
                    check("done_err",      int'(sif.err),       int'(mon_e.err));
                    check("done_err_layer", int'(sif.err_layer), mon_e.err_layer);
                    check("starts_per_job", starts,              1);
                end
                starts = 0;
            end
        end
    end

    initial begin
        sif.req = '0;
        rst     = 1'b1;
        model_reset();
        step(3);
        check_all_zero("reset");
        rst = 1'b0;
        step(2);

        // Single request with fixed updater latency 6: relative cycle t = 0.
        lat_fixed = 6;
        model_batch(4'b0100, 4'b0000);
        sif.req = 4'b0100;
        step(1);
        sif.req = '0;
        check("single_busy_t1", int'(sif.busy), 0);
        step(1);
        check("single_layer_sel_t2", int'(sif.layer_sel), 2);
        check("single_busy_t2", int'(sif.busy), 1);
        check("single_start_t2", int'(sif.upd_start), 0);
        step(1);
        check("single_start_t3", int'(sif.upd_start), 1);
        wr_cyc = -1;
        busy10 = -1;
        busy11 = -1;
        for (int c = 4; c <= 11; c++) begin
            step(1);
            if (sif.wr_en && wr_cyc < 0) wr_cyc = c;
            if (c == 10) busy10 = int'(sif.busy);
            if (c == 11) busy11 = int'(sif.busy);
        end
        check("single_wr_cycle", wr_cyc, 10);
        check("single_busy_t10", busy10, 1);
        check("single_busy_t11", busy11, 0);
        wait_idle();
        lat_fixed = 0;

        // Round-robin from reset, with a late request for layer 0 during job 3.
        do_reset();
        model_batch(4'b1011, 4'b0000);
        pulse_req(4'b1011);
        wait_start("rr_layer3_start", 3, found);
        model_batch(4'b0001, 4'b0000);
        pulse_req(4'b0001);
        wait_idle();

        // Request for layer 1 held into its own grant cycle: serviced twice.
        model_batch(4'b0010, 4'b0000);
        model_batch(4'b0010, 4'b0000);
        sif.req = 4'b0010;
        step(2);
        sif.req = '0;
        wait_idle();

        // Error on layer 3, then a clean job keeps err sticky.
        err_mask = 4'b1000;
        model_batch(4'b1000, 4'b1000);
        pulse_req(4'b1000);
        wait_idle();
        err_mask = 4'b0000;
        model_batch(4'b0001, 4'b0000);
        pulse_req(4'b0001);
        wait_idle();
        check("err_sticky", int'(sif.err), 1);
        check("err_layer_hold", int'(sif.err_layer), 3);

        // Reset during WAIT of layer 2.
        lat_fixed = 8;
        model_batch(4'b0100, 4'b0000);
        pulse_req(4'b0100);
        wait_start("midreset_start", 2, found);
        step(2);
        rst = 1'b1;
        step(1);
        check_all_zero("midreset");
        rst = 1'b0;
        model_reset();
        lat_fixed = 0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (sif.busy) cnt++;
        end
        check("midreset_no_pending", cnt, 0);
        model_batch(4'b1111, 4'b0000);
        pulse_req(4'b1111);
        wait_idle();

        // Randomized batches from idle.
        for (int b = 0; b < 30; b++) begin
            rv = NL'($urandom_range(1, (1 << NL) - 1));
            ev = ($urandom_range(0, 3) == 0) ? NL'($urandom_range(0, (1 << NL) - 1)) : '0;
            err_mask = ev;
            model_batch(rv, ev);
            pulse_req(rv);
            wait_idle();
        end
        err_mask = '0;

`ifdef UPDATE_TIMEOUT_EN
        do_reset();
        upd_hang = 1'b1;
        model_batch(4'b0001, 4'b0001);
        pulse_req(4'b0001);
        wait_start("wd_start", 0, found);
        cnt = 0;
        while (sif.done == '0 && cnt < 100) begin
            step(1);
            cnt++;
        end
        check("wd_done_delay", cnt, TO + 1);
        check("wd_timeout", int'(sif.timeout), 1);
        check("wd_no_wr_en", int'(sif.wr_en), 0);
        step(1);
        check("wd_idle_after", int'(sif.busy), 0);
        upd_hang = 1'b0;
`else
        do_reset();
        upd_hang = 1'b1;
        pulse_req(4'b0001);
        step(1);
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            step(1);
            if (!sif.busy) cnt++;
        end
        check("hang_busy_low_cycles", cnt, 0);
        check("hang_timeout", int'(sif.timeout), 0);
        do_reset();
        upd_hang = 1'b0;
`endif
        step(2);
        check("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
